mdr_host: RTL

Initiator side of the MDR (multiply/divide/root) load/start protocol. Accepts operation requests (op, X, Y) over a valid/ready channel and sequences the MDR handshake: start, load X on `load_x`, load Y on `load_y`, completion on `ready`/`error`. Returns result, remainder and status over a valid/ready response channel. Sits between a command source (CPU bridge or test sequencer) and `mdr_top`.

---
 rtl/mdr_pkg.sv | 39 +++
 rtl/mdr_host_timer.sv | 30 +++
 rtl/mdr_host.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mdr_pkg.sv
// mdr_pkg: shared types for the MDR initiator (operation codes, FSM states, response bundle).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mdr_pkg;

   // Default operand/result width. Hosts built with a different DW must not exceed it.
   localparam int MDR_DW = 16;

   typedef enum logic [1:0] {
      MDR_MUL  = 2'd0,
      MDR_DIV  = 2'd1,
      MDR_SQRT = 2'd2,
      MDR_RSVD = 2'd3
   } mdr_op_e;

   // WAIT_DONE is not a separate encoding: it is ST_WAIT_Y with the Y operand already loaded.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_WAIT_X = 3'd2,
      ST_LOAD_X = 3'd3,
      ST_WAIT_Y = 3'd4,
      ST_LOAD_Y = 3'd5,
      ST_RESP   = 3'd6
   } mdr_host_state_e;

   typedef struct packed {
      logic [MDR_DW-1:0] result;
      logic [MDR_DW-1:0] remainder;
      logic              error;
      logic              timeout;
   } mdr_rsp_t;

   // States in which the host is waiting on the MDR and the watchdog may run.
   function automatic logic is_wait_state(mdr_host_state_e s);
      return (s == ST_WAIT_X) || (s == ST_WAIT_Y);
   endfunction

endpackage

// File: rtl/mdr_host_timer.sv
// mdr_host_timer: clearable saturating cycle counter with an expiry flag (watchdog for mdr_host).
// Latency: o_expired is registered-count based; it rises LIMIT increments after the last clear.
// Backpressure: none; i_clr has priority over i_inc. Ports: i_clk, i_rst_n, i_clr, i_inc, o_expired.
module mdr_host_timer #(
   parameter int LIMIT = 255   // must be >= 1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != CW'(LIMIT))) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expired = (r_cnt == CW'(LIMIT));

endmodule

// File: rtl/mdr_host.sv
// mdr_host: initiator for the MDR start/load protocol; takes (op, x, y) requests and returns result/remainder/status.
// Latency: all outputs registered; MUL/DIV >= 7 cycles request-to-response, SQRT >= 5, reserved op 1 cycle.
// Backpressure: one operation in flight; req_ready low from accept until back in IDLE, response held until rsp_ready.
// Ports: clk/rst (async active-low); req_* request channel; rsp_* response channel; mdr_* drive/observe the MDR; busy.
// Optional watchdog: define MDR_HOST_TIMEOUT_EN to abort wait states after TIMEOUT_CYC cycles (rsp_timeout/rsp_error).
module mdr_host
   import mdr_pkg::*;
#(
   parameter int DW          = MDR_DW,   // must not exceed MDR_DW
   parameter int TIMEOUT_CYC = 255
) (
   input  logic          clk,
   input  logic          rst,
   // request channel
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [1:0]    req_op,
   input  logic [DW-1:0] req_x,
   input  logic [DW-1:0] req_y,
   // response channel
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_result,
   output logic [DW-1:0] rsp_remainder,
   output logic          rsp_error,
   output logic          rsp_timeout,
   // MDR side
   output logic          mdr_start,
   output logic          mdr_load,
   output logic [1:0]    mdr_op,
   output logic [DW-1:0] mdr_data,
   input  logic          mdr_load_x,
   input  logic          mdr_load_y,
   input  logic          mdr_ready,
   input  logic          mdr_error,
   input  logic [DW-1:0] mdr_result,
   input  logic [DW-1:0] mdr_remainder,
   output logic          busy
);

   mdr_host_state_e r_state, w_next;
   mdr_op_e         w_req_op;
   logic            w_accept;
   logic            w_done;
   logic            w_expired;
   logic            w_cap_done;
   logic            w_cap_timeout;

   logic            r_req_ready;
   logic            r_busy;
   logic            r_mdr_start;
   logic            r_mdr_load;
   mdr_op_e         r_mdr_op;
   logic [DW-1:0]   r_mdr_data;
   logic [DW-1:0]   r_x;
   logic [DW-1:0]   r_y;
   logic            r_y_loaded;   // distinguishes WAIT_DONE from WAIT_Y
   logic            r_rsp_valid;
   mdr_rsp_t        r_rsp;

   assign w_req_op = mdr_op_e'(req_op);
   // r_req_ready is 0 only in the first IDLE cycle after reset.
   assign w_accept = (r_state == ST_IDLE) && r_req_ready && req_valid;
   assign w_done   = mdr_ready | mdr_error;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ---------------- FSM: next state ----------------
   // Completion beats load requests and watchdog expiry; a pending load beats expiry.
   always_comb begin
      w_next        = r_state;
      w_cap_done    = 1'b0;
      w_cap_timeout = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_next = (w_req_op == MDR_RSVD) ? ST_RESP : ST_START;
            end
         end
         ST_START:  w_next = ST_WAIT_X;
         ST_WAIT_X: begin
            if (w_done) begin
               w_next     = ST_RESP;
               w_cap_done = 1'b1;
            end else if (mdr_load_x) begin
               w_next = ST_LOAD_X;
            end else if (w_expired) begin
               w_next        = ST_RESP;
               w_cap_timeout = 1'b1;
            end
         end
         ST_LOAD_X: w_next = ST_WAIT_Y;
         ST_WAIT_Y: begin
            if (w_done) begin
               w_next     = ST_RESP;
               w_cap_done = 1'b1;
            end else if (mdr_load_y && !r_y_loaded) begin
               w_next = ST_LOAD_Y;
            end else if (w_expired) begin
               w_next        = ST_RESP;
               w_cap_timeout = 1'b1;
            end
         end
         ST_LOAD_Y: w_next = ST_WAIT_Y;
         ST_RESP: begin
            if (rsp_ready) begin
               w_next = ST_IDLE;
            end
         end
         default:   w_next = ST_IDLE;
      endcase
   end

   // ---------------- watchdog ----------------
`ifdef MDR_HOST_TIMEOUT_EN
   logic w_tmr_inc;
   logic w_tmr_clr;

   assign w_tmr_inc = is_wait_state(r_state);
   // Any state change restarts the count, including LOAD_Y -> WAIT_DONE.
   assign w_tmr_clr = (w_next != r_state) || !w_tmr_inc;

   mdr_host_timer #(
      .LIMIT(TIMEOUT_CYC)
   ) u_timer (
      .i_clk    (clk),
      .i_rst_n  (rst),
      .i_clr    (w_tmr_clr),
      .i_inc    (w_tmr_inc),
      .o_expired(w_expired)
   );
`else
   assign w_expired = 1'b0;
`endif

   // ---------------- registered outputs and operand latches ----------------
   // Outputs are decoded from the next state so they line up with the state they describe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_req_ready <= 1'b0;
         r_busy      <= 1'b0;
         r_mdr_start <= 1'b0;
         r_mdr_load  <= 1'b0;
         r_mdr_op    <= MDR_MUL;
         r_mdr_data  <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_y_loaded  <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp       <= '0;
      end else begin
         r_req_ready <= (w_next == ST_IDLE);
         r_busy      <= (w_next != ST_IDLE);
         r_mdr_start <= (w_next == ST_START);
         r_mdr_load  <= (w_next == ST_LOAD_X) || (w_next == ST_LOAD_Y);
         r_rsp_valid <= (w_next == ST_RESP);

         if (w_accept) begin
            r_x <= req_x;
            r_y <= req_y;
         end

         // mdr_op is presented with the start pulse and held until the response retires.
         if (w_accept && (w_req_op != MDR_RSVD)) begin
            r_mdr_op <= w_req_op;
         end else if (w_next == ST_IDLE) begin
            r_mdr_op <= MDR_MUL;
         end

         // mdr_data keeps the last loaded operand between loads.
         if (w_next == ST_LOAD_X) begin
            r_mdr_data <= r_x;
         end else if (w_next == ST_LOAD_Y) begin
            r_mdr_data <= r_y;
         end

         if (w_next == ST_LOAD_Y) begin
            r_y_loaded <= 1'b1;
         end else if (w_next == ST_IDLE) begin
            r_y_loaded <= 1'b0;
         end

         // Response fields: cleared (or reserved-op error) at accept, captured on completion/expiry.
         if (w_accept) begin
            r_rsp <= '{result: '0, remainder: '0, error: (w_req_op == MDR_RSVD), timeout: 1'b0};
         end else if (w_cap_done) begin
            r_rsp <= '{result: MDR_DW'(mdr_result), remainder: MDR_DW'(mdr_remainder),
                       error: mdr_error, timeout: 1'b0};
         end else if (w_cap_timeout) begin
            r_rsp <= '{result: '0, remainder: '0, error: 1'b1, timeout: 1'b1};
         end
      end
   end

   assign req_ready     = r_req_ready;
   assign busy          = r_busy;
   assign mdr_start     = r_mdr_start;
   assign mdr_load      = r_mdr_load;
   assign mdr_op        = r_mdr_op;
   assign mdr_data      = r_mdr_data;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_result    = r_rsp.result[DW-1:0];
   assign rsp_remainder = r_rsp.remainder[DW-1:0];
   assign rsp_error     = r_rsp.error;
   // Only the watchdog path ever sets the timeout bit, so it stays 0 without the timer.
   assign rsp_timeout   = r_rsp.timeout;

endmodule
